mio_bus_ctrl: RTL and testbench
===============================

Name: mio_bus_ctrl

Overview:
Memory/IO bus controller directly downstream of the single-cycle CPU's data port. It takes the CPU's MIO request (address, write data, write enable) and either runs a variable-latency handshake with the data RAM or serves an on-chip peripheral register (LED, switches, free-running counter). It returns read data and a one-cycle MIO_ready pulse that stalls/releases the CPU.

Parameters:
RAM_AW, 10, RAM word-address width; RAM window is byte addresses 0 .. 4*2^RAM_AW-1
TIMEOUT, 16, max cycles in RAM_WAIT before the access is abandoned with error
LED_ADDR, 32'hE000_0000, LED register byte address (R/W)
SW_ADDR, 32'hF000_0000, switch register byte address (RO)
CNT_ADDR, 32'hF000_0004, counter register byte address (R/W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request (CPU_MIO); held until MIO_ready
cpu_we  in  1  1 = write, 0 = read (mem_w)
cpu_addr  in  32  byte address (Addr_out); bits [1:0] ignored
cpu_wdata  in  32  write data (Data_out)
cpu_rdata  out  32  read data to CPU (Data_in)
MIO_ready  out  1  one-cycle completion pulse
bus_err  out  1  sticky error flag
ram_en  out  1  RAM strobe, exactly one cycle per RAM access
ram_we  out  1  RAM write enable, valid with ram_en
ram_addr  out  RAM_AW  RAM word address = cpu_addr[RAM_AW+1:2]
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completion, earliest one cycle after ram_en
sw  in  16  raw asynchronous switch inputs
led  out  16  LED register

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; MIO_ready, ram_en, ram_we, bus_err, led, cpu_rdata, counter, ram_addr, ram_wdata all 0; in-flight access aborted, ram_en drops immediately.
- FSM states: IDLE, RAM_REQ, RAM_WAIT, RESP.
- IDLE: on clk with cpu_req=1 latch addr/we/wdata and decode:
  - RAM window -> RAM_REQ.
  - LED/SW/CNT -> perform access at this edge (write updates register; read captures value into cpu_rdata) -> RESP.
  - Unmapped -> cpu_rdata=0, bus_err<=1, writes discarded -> RESP.
- RAM_REQ: ram_en=1, ram_we=latched we, ram_addr/ram_wdata driven from latched values; unconditionally -> RAM_WAIT; timeout counter cleared.
- RAM_WAIT: ram_ack=1 -> capture ram_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged) -> RESP. Otherwise increment timeout counter; on reaching TIMEOUT -> cpu_rdata=0, bus_err<=1 -> RESP. ram_ack outside RAM_WAIT is ignored.
- RESP: MIO_ready=1 for exactly this cycle; cpu_rdata stable; -> IDLE. New request sampled the following IDLE cycle (back-to-back allowed; cpu_req still high then starts a new access).
- Latency (req sampled at edge N): peripheral/unmapped ready in cycle N+1; RAM ready = cycle after ack (min N+3).
- Counter: 32-bit, +1 every cycle, wraps FFFF_FFFF->0. Write to CNT_ADDR loads cpu_wdata; load wins over increment that cycle. Read returns value at the latch edge.
- SW read: {16'h0, sw_sync}; sw passes a 2-flop synchronizer (2-cycle delay). Writes to SW_ADDR ignored, no error.
- LED read: {16'h0, led}; write loads cpu_wdata[15:0].
- bus_err clears only on reset.
- cpu_rdata holds last value outside RESP.

Test Plan:
- Reset held low 3 cycles mid RAM_WAIT -> ram_en=0, MIO_ready=0, led=0 immediately; after release FSM IDLE, next req served normally.
- Write 32'h0000_A5A5 to E000_0000 then read -> led=16'hA5A5 one cycle after req, read returns 32'h0000_A5A5, MIO_ready exactly one cycle each.
- RAM read addr 0x0000_000C, ram_ack 3 cycles after ram_en with rdata 5A5A_A5A5 -> ram_addr=3, ram_en one cycle, cpu_rdata=5A5A_A5A5 with MIO_ready the cycle after ack.
- RAM write, ram_ack never asserted -> after TIMEOUT(16) cycles MIO_ready=1, cpu_rdata=0, bus_err=1.
- Write FFFF_FFFE to F000_0004, read back immediately -> value FFFF_FFFE+elapsed cycles, wrapping through 0.
- Read unmapped 8000_0000 -> cpu_rdata=0, bus_err=1, ram_en never asserted.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// MIO bus controller: bridges the CPU data port to a variable-latency
// data RAM handshake and a small set of on-chip peripheral registers.
module mio_bus_ctrl #(
    parameter int          RAM_AW   = 10,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] LED_ADDR = 32'hE000_0000,
    parameter logic [31:0] SW_ADDR  = 32'hF000_0000,
    parameter logic [31:0] CNT_ADDR = 32'hF000_0004
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack,
    input  logic [15:0]       sw,
    output logic [15:0]       led
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RAM_REQ,
        RAM_WAIT,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        lat_we;
    logic [31:0] cnt_q;
    logic [15:0] sw_meta;
    logic [15:0] sw_sync;
    logic [TW-1:0] tmo_q;

    logic        hit_ram;
    logic        hit_led;
    logic        hit_sw;
    logic        hit_cnt;

    logic        lat_en;
    logic        rd_load;
    logic [31:0] rd_val;
    logic        err_set;
    logic        led_we;
    logic        cnt_we;
    logic        tmo_clr;
    logic        tmo_inc;

    // Byte-offset bits never take part in decode.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign hit_ram = (cpu_addr[31:RAM_AW+2] == '0);
    assign hit_led = (cpu_addr[31:2] == LED_ADDR[31:2]);
    assign hit_sw  = (cpu_addr[31:2] == SW_ADDR[31:2]);
    assign hit_cnt = (cpu_addr[31:2] == CNT_ADDR[31:2]);

    assign MIO_ready = (state_q == RESP);
    assign ram_en    = (state_q == RAM_REQ);
    assign ram_we    = ram_en & lat_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_en  = 1'b0;
        rd_load = 1'b0;
        rd_val  = '0;
        err_set = 1'b0;
        led_we  = 1'b0;
        cnt_we  = 1'b0;
        tmo_clr = 1'b0;
        tmo_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    lat_en  = 1'b1;
                    state_d = RESP;
                    unique case (1'b1)
                        hit_ram: begin
                            state_d = RAM_REQ;
                        end
                        hit_led: begin
                            led_we  = cpu_we;
                            rd_load = !cpu_we;
                            rd_val  = {16'h0, led};
                        end
                        hit_sw: begin
                            rd_load = !cpu_we;
                            rd_val  = {16'h0, sw_sync};
                        end
                        hit_cnt: begin
                            cnt_we  = cpu_we;
                            rd_load = !cpu_we;
                            rd_val  = cnt_q;
                        end
                        default: begin
                            rd_load = 1'b1;
                            err_set = 1'b1;
                        end
                    endcase
                end
            end
            RAM_REQ: begin
                tmo_clr = 1'b1;
                state_d = RAM_WAIT;
            end
            RAM_WAIT: begin
                if (ram_ack) begin
                    rd_load = !lat_we;
                    rd_val  = ram_rdata;
                    state_d = RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Abandon the access: zero data, sticky error.
                    rd_load = 1'b1;
                    err_set = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_rdata <= '0;
            bus_err   <= 1'b0;
            led       <= '0;
            cnt_q     <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            tmo_q     <= '0;
        end else begin
            cnt_q   <= cnt_we ? cpu_wdata : cnt_q + 32'd1;
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (lat_en) begin
                lat_we    <= cpu_we;
                ram_addr  <= cpu_addr[RAM_AW+1:2];
                ram_wdata <= cpu_wdata;
            end
            if (led_we) begin
                led <= cpu_wdata[15:0];
            end
            if (rd_load) begin
                cpu_rdata <= rd_val;
            end
            if (err_set) begin
                bus_err <= 1'b1;
            end
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl with a behavioural RAM responder.
module tb_mio_bus_ctrl;

    localparam int RAM_AW = 10;
    localparam logic [31:0] LED = 32'hE000_0000;
    localparam logic [31:0] SWA = 32'hF000_0000;
    localparam logic [31:0] CNT = 32'hF000_0004;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              MIO_ready;
    logic              bus_err;
    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;
    logic              ram_ack = 1'b0;
    logic [15:0]       sw = 16'h1234;
    logic [15:0]       led;

    mio_bus_ctrl #(.RAM_AW(RAM_AW), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
        .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .sw(sw), .led(led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        bit          chk_rd;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every completion pulse.
    logic prev_rdy = 1'b0;
    exp_t e_mon;
    always @(negedge clk) begin
        if (MIO_ready) begin
            chk("rdy_pulse", 32'(prev_rdy), 32'd0);
            if (sb.size() == 0) begin
                chk("rdy_spurious", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                if (e_mon.chk_rd) chk("rdata", cpu_rdata, e_mon.rd);
                chk("err", 32'(bus_err), 32'(e_mon.err));
                chk("latency", 32'(cyc - e_mon.acc), 32'(e_mon.lat));
            end
        end
        prev_rdy = MIO_ready;
    end

    int n_en = 0;
    always @(negedge clk) if (ram_en) n_en++;

    int                ack_d = -1;
    logic [31:0]       rsp_data = '0;
    logic [RAM_AW-1:0] exp_ra = '0;
    bit                exp_rwe = 1'b0;
    logic [31:0]       exp_rwd = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (ram_en) begin
                chk("ram_addr", 32'(ram_addr), 32'(exp_ra));
                chk("ram_we", 32'(ram_we), 32'(exp_rwe));
                if (exp_rwe) chk("ram_wdata", ram_wdata, exp_rwd);
                if (ack_d >= 0) begin
                    repeat (ack_d) @(negedge clk);
                    ram_rdata = rsp_data;
                    ram_ack   = 1'b1;
                    @(negedge clk);
                    ram_ack   = 1'b0;
                end
            end
        end
    end

    logic [31:0] cnt_w = '0;
    int          cnt_a = 0;

    task automatic access(input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit chk_rd, input bit exp_err,
                          input int lat, input int d,
                          input logic [31:0] rsp);
        exp_t e;
        int   en0;
        bit   is_ram;
        bit   done;
        is_ram = (addr < 32'(4 * (1 << RAM_AW)));
        @(negedge clk);
        ack_d    = d;
        rsp_data = rsp;
        exp_ra   = addr[RAM_AW+1:2];
        exp_rwe  = we;
        exp_rwd  = wd;
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        e.acc    = cyc + 1;
        e.rd     = exp_rd;
        e.chk_rd = chk_rd;
        e.err    = exp_err;
        e.lat    = lat;
        if (addr == CNT && !we) e.rd = cnt_w + 32'(e.acc - 1 - cnt_a);
        if (addr == CNT && we) begin
            cnt_w = wd;
            cnt_a = e.acc;
        end
        sb.push_back(e);
        en0  = n_en;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (MIO_ready) done = 1'b1;
        end
        cpu_req = 1'b0;
        if (!done) begin
            chk("ready_wait", 32'd0, 32'd1);
            void'(sb.pop_back());
        end
        chk("ram_en_cnt", 32'(n_en - en0), is_ram ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(MIO_ready), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        reset = 1'b1;

        access(1, LED, 32'h0000_A5A5, 32'h0, 1, 0, 0, -1, 0);
        chk("led_after_wr", 32'(led), 32'h0000_A5A5);
        access(0, LED, 32'h0, 32'h0000_A5A5, 1, 0, 0, -1, 0);
        access(0, SWA, 32'h0, 32'h0000_1234, 1, 0, 0, -1, 0);
        access(1, SWA, 32'hDEAD_BEEF, 32'h0000_1234, 1, 0, 0, -1, 0);
        sw = 16'hBEEF;
        repeat (4) @(negedge clk);
        access(0, SWA, 32'h0, 32'h0000_BEEF, 1, 0, 0, -1, 0);

        access(0, 32'h0000_000C, 32'h0, 32'h5A5A_A5A5, 1, 0, 4, 3,
               32'h5A5A_A5A5);
        access(1, 32'h0000_0010, 32'h1111_2222, 32'h5A5A_A5A5, 1, 0, 3, 2,
               32'hFFFF_FFFF);
        access(1, 32'h0000_0014, 32'h3333_4444, 32'h0, 1, 1, 17, -1, 0);

        access(1, CNT, 32'hFFFF_FFFE, 32'h0, 1, 1, 0, -1, 0);
        access(0, CNT, 32'h0, 32'h0, 1, 1, 0, -1, 0);
        repeat (5) @(negedge clk);
        access(0, CNT, 32'h0, 32'h0, 1, 1, 0, -1, 0);

        // Reset in the middle of a RAM wait that would never be acked.
        @(negedge clk);
        ack_d    = -1;
        exp_ra   = 8;
        exp_rwe  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0020;
        seen     = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (ram_en) seen = 1'b1;
        end
        chk("mid_ram_en_seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(MIO_ready), 32'd0);
        chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
        chk("mid_rst_led", 32'(led), 32'd0);
        chk("mid_rst_err", 32'(bus_err), 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_rst_ram_en", 32'(ram_en), 32'd0);
        reset = 1'b1;

        access(0, 32'h8000_0000, 32'h0, 32'h0, 1, 1, 0, -1, 0);
        access(0, LED, 32'h0, 32'h0, 1, 1, 0, -1, 0);
        access(0, 32'h0000_0024, 32'h0, 32'h1234_5678, 1, 1, 2, 1,
               32'h1234_5678);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
